// File: rtl/jtdd2_shared_arb.sv
// Single-port arbiter for the DD2 main/sub shared RAM: round-robin grant,
// fixed IDLE -> ACC -> CAP access sequence, level ok handshakes per requester.
module jtdd2_shared_arb #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          main_cs,
    input  logic          main_wrn,
    input  logic [AW-1:0] main_addr,
    input  logic [DW-1:0] main_dout,
    output logic [DW-1:0] main_din,
    output logic          main_ok,
    input  logic          sub_cs,
    input  logic          sub_wrn,
    input  logic [AW-1:0] sub_addr,
    input  logic [DW-1:0] sub_dout,
    output logic [DW-1:0] sub_din,
    output logic          sub_ok,
    input  logic          mcu_halt,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          sub_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_CAP
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_last_sub;
    logic          r_win_sub;
    logic          r_wrn;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic [DW-1:0] r_main_din;
    logic [DW-1:0] r_sub_din;
    logic          r_main_done;
    logic          r_sub_done;

    logic          w_main_pend;
    logic          w_sub_pend;
    logic          w_grant;
    logic          w_grant_sub;

    assign w_main_pend = main_cs & ~r_main_done;
    assign w_sub_pend  = sub_cs & ~r_sub_done & ~mcu_halt;

    // On a tie the side that was not served last wins
    always_comb begin
        w_grant     = (r_state == ST_IDLE) & (w_main_pend | w_sub_pend);
        w_grant_sub = w_sub_pend & (~w_main_pend | ~r_last_sub);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_next = ST_ACC;
            ST_ACC:  w_next = ST_CAP;
            ST_CAP:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_we   = 1'b0;
        sub_busy = 1'b0;
        case (r_state)
            ST_ACC: begin
                ram_we   = ~r_wrn;
                sub_busy = r_win_sub;
            end
            ST_CAP: begin
                sub_busy = r_win_sub;
            end
            default: begin
                ram_we   = 1'b0;
                sub_busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_sub <= 1'b0;
            r_wrn     <= 1'b1;
            r_addr    <= '0;
            r_data    <= '0;
        end else if (w_grant) begin
            r_win_sub <= w_grant_sub;
            r_wrn     <= w_grant_sub ? sub_wrn   : main_wrn;
            r_addr    <= w_grant_sub ? sub_addr  : main_addr;
            r_data    <= w_grant_sub ? sub_dout  : main_dout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_sub <= 1'b1;
            r_main_din <= '0;
            r_sub_din  <= '0;
        end else if (r_state == ST_CAP) begin
            r_last_sub <= r_win_sub;
            if (r_wrn) begin
                if (r_win_sub) r_sub_din  <= ram_q;
                else           r_main_din <= ram_q;
            end
        end
    end

    // Completion wins over clearing, so a cs dropped mid-access still shows one ok cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_done <= 1'b0;
            r_sub_done  <= 1'b0;
        end else begin
            if (r_state == ST_CAP && !r_win_sub) r_main_done <= 1'b1;
            else if (!main_cs)                   r_main_done <= 1'b0;
            if (r_state == ST_CAP && r_win_sub)  r_sub_done  <= 1'b1;
            else if (!sub_cs)                    r_sub_done  <= 1'b0;
        end
    end

    assign main_din = r_main_din;
    assign sub_din  = r_sub_din;
    assign main_ok  = r_main_done;
    assign sub_ok   = r_sub_done;
    assign ram_addr = r_addr;
    assign ram_data = r_data;

endmodule

// File: tb/tb_jtdd2_shared_arb.sv
// Directed bench for jtdd2_shared_arb with a behavioural synchronous-read RAM.
module tb_jtdd2_shared_arb;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          main_cs, main_wrn, sub_cs, sub_wrn, mcu_halt;
    logic [AW-1:0] main_addr, sub_addr;
    logic [DW-1:0] main_dout, sub_dout;
    logic [DW-1:0] main_din, sub_din;
    logic          main_ok, sub_ok, ram_we, sub_busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    jtdd2_shared_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr),
        .main_dout(main_dout), .main_din(main_din), .main_ok(main_ok),
        .sub_cs(sub_cs), .sub_wrn(sub_wrn), .sub_addr(sub_addr),
        .sub_dout(sub_dout), .sub_din(sub_din), .sub_ok(sub_ok),
        .mcu_halt(mcu_halt),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
        .ram_q(ram_q), .sub_busy(sub_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        main_cs = 0; main_wrn = 1; main_addr = '0; main_dout = '0;
        sub_cs = 0;  sub_wrn = 1;  sub_addr = '0;  sub_dout = '0;
        mcu_halt = 0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
        repeat (2) tick();
        checks++; if (main_din !== 8'h00) begin failures++; $display("FAIL reset_main_din got=%h exp=00", main_din); end
        checks++; if (sub_din !== 8'h00) begin failures++; $display("FAIL reset_sub_din got=%h exp=00", sub_din); end
        checks++; if (main_ok !== 1'b0) begin failures++; $display("FAIL reset_main_ok got=%b exp=0", main_ok); end
        checks++; if (sub_ok !== 1'b0) begin failures++; $display("FAIL reset_sub_ok got=%b exp=0", sub_ok); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        checks++; if (ram_addr !== 10'h000) begin failures++; $display("FAIL reset_ram_addr got=%h exp=000", ram_addr); end
        checks++; if (ram_data !== 8'h00) begin failures++; $display("FAIL reset_ram_data got=%h exp=00", ram_data); end
        checks++; if (sub_busy !== 1'b0) begin failures++; $display("FAIL reset_sub_busy got=%b exp=0", sub_busy); end
        rst = 1'b0;
    endtask

    task automatic test_main_read();
        int lat = 0;
        int we_seen = 0;
        mem[10'h123] = 8'hA5;
        main_wrn = 1; main_addr = 10'h123; main_cs = 1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (ram_we) we_seen = 1;
            if (main_ok) lat = i;
        end
        checks++; if (lat !== 3) begin failures++; $display("FAIL main_read_latency got=%0d exp=3", lat); end
        checks++; if (we_seen !== 0) begin failures++; $display("FAIL main_read_no_we got=%0d exp=0", we_seen); end
        checks++; if (main_din !== 8'hA5) begin failures++; $display("FAIL main_read_data got=%h exp=a5", main_din); end
        repeat (3) tick();
        checks++; if (main_ok !== 1'b1) begin failures++; $display("FAIL main_ok_held got=%b exp=1", main_ok); end
        main_cs = 0;
        tick();
        checks++; if (main_ok !== 1'b0) begin failures++; $display("FAIL main_ok_clear got=%b exp=0", main_ok); end
    endtask

    task automatic test_sub_write();
        int lat = 0;
        int pulses = 0;
        int busy = 0;
        logic [AW-1:0] wa = '0;
        logic [DW-1:0] wd = '0;
        sub_wrn = 0; sub_addr = 10'h200; sub_dout = 8'h3C; sub_cs = 1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (ram_we) begin pulses++; wa = ram_addr; wd = ram_data; end
            if (sub_busy) busy++;
            if (sub_ok) lat = i;
        end
        checks++; if (lat !== 3) begin failures++; $display("FAIL sub_write_latency got=%0d exp=3", lat); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL sub_write_pulses got=%0d exp=1", pulses); end
        checks++; if (wa !== 10'h200) begin failures++; $display("FAIL sub_write_addr got=%h exp=200", wa); end
        checks++; if (wd !== 8'h3C) begin failures++; $display("FAIL sub_write_data got=%h exp=3c", wd); end
        checks++; if (busy !== 2) begin failures++; $display("FAIL sub_busy_cycles got=%0d exp=2", busy); end
        sub_cs = 0; sub_wrn = 1;
        tick();
        lat = 0;
        main_wrn = 1; main_addr = 10'h200; main_cs = 1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (main_ok) lat = i;
        end
        checks++; if (main_din !== 8'h3C) begin failures++; $display("FAIL readback_data got=%h exp=3c", main_din); end
        main_cs = 0;
        tick();
    endtask

    task automatic run_tie(input logic [AW-1:0] ma, input logic [AW-1:0] sa,
                           input logic [DW-1:0] md, input logic [DW-1:0] sd,
                           input int em, input int es, input string tag);
        int lm = 0;
        int ls = 0;
        mem[ma] = md; mem[sa] = sd;
        main_wrn = 1; sub_wrn = 1; main_addr = ma; sub_addr = sa;
        main_cs = 1; sub_cs = 1;
        for (int i = 1; i <= 12 && (lm == 0 || ls == 0); i++) begin
            tick();
            if (main_ok && lm == 0) lm = i;
            if (sub_ok && ls == 0) ls = i;
        end
        checks++; if (lm !== em) begin failures++; $display("FAIL %s_main_lat got=%0d exp=%0d", tag, lm, em); end
        checks++; if (ls !== es) begin failures++; $display("FAIL %s_sub_lat got=%0d exp=%0d", tag, ls, es); end
        checks++; if (main_din !== md) begin failures++; $display("FAIL %s_main_din got=%h exp=%h", tag, main_din, md); end
        checks++; if (sub_din !== sd) begin failures++; $display("FAIL %s_sub_din got=%h exp=%h", tag, sub_din, sd); end
        main_cs = 0; sub_cs = 0;
        tick();
    endtask

    task automatic test_tie();
        int lat = 0;
        rst = 1; tick(); rst = 0;
        run_tie(10'h010, 10'h011, 8'h11, 8'h22, 3, 6, "tie_reset");
        // sub was served last, so main wins again
        run_tie(10'h012, 10'h013, 8'h33, 8'h44, 3, 6, "tie_after_sub");
        main_wrn = 1; main_addr = 10'h010; main_cs = 1;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (main_ok) lat = i;
        end
        main_cs = 0;
        tick();
        run_tie(10'h014, 10'h015, 8'h55, 8'h66, 6, 3, "tie_after_main");
    endtask

    task automatic test_halt();
        int lm = 0;
        int ls = 0;
        int sub_seen = 0;
        int busy_seen = 0;
        mcu_halt = 1;
        sub_wrn = 1; sub_addr = 10'h011; sub_cs = 1;
        main_wrn = 1; main_addr = 10'h012; main_cs = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (sub_ok) sub_seen = 1;
            if (sub_busy) busy_seen = 1;
            if (main_ok && lm == 0) begin lm = i; main_cs = 0; end
        end
        checks++; if (lm !== 3) begin failures++; $display("FAIL halt_main_lat got=%0d exp=3", lm); end
        checks++; if (sub_seen !== 0) begin failures++; $display("FAIL halt_sub_ok got=%0d exp=0", sub_seen); end
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL halt_sub_busy got=%0d exp=0", busy_seen); end
        checks++; if (main_din !== 8'h33) begin failures++; $display("FAIL halt_main_din got=%h exp=33", main_din); end
        mcu_halt = 0;
        for (int i = 1; i <= 8 && ls == 0; i++) begin
            tick();
            if (sub_ok) ls = i;
        end
        checks++; if (ls !== 3) begin failures++; $display("FAIL unhalt_sub_lat got=%0d exp=3", ls); end
        checks++; if (sub_din !== 8'h22) begin failures++; $display("FAIL unhalt_sub_din got=%h exp=22", sub_din); end
        sub_cs = 0;
        tick();
        ls = 0;
        sub_addr = 10'h013; sub_cs = 1;
        tick();
        checks++; if (sub_busy !== 1'b1) begin failures++; $display("FAIL midhalt_busy got=%b exp=1", sub_busy); end
        mcu_halt = 1;
        for (int i = 2; i <= 8 && ls == 0; i++) begin
            tick();
            if (sub_ok) ls = i;
        end
        checks++; if (ls !== 3) begin failures++; $display("FAIL midhalt_sub_lat got=%0d exp=3", ls); end
        checks++; if (sub_din !== 8'h44) begin failures++; $display("FAIL midhalt_sub_din got=%h exp=44", sub_din); end
        mcu_halt = 0; sub_cs = 0;
        tick();
    endtask

    task automatic test_held_cs();
        int lm = 0;
        int pulses = 0;
        int ok_drop = 0;
        main_wrn = 0; main_addr = 10'h050; main_dout = 8'h5A; main_cs = 1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (ram_we) pulses++;
            if (main_ok && lm == 0) lm = i;
            if (lm != 0 && !main_ok) ok_drop = 1;
        end
        checks++; if (lm !== 3) begin failures++; $display("FAIL held_lat got=%0d exp=3", lm); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
        checks++; if (ok_drop !== 0) begin failures++; $display("FAIL held_ok_drop got=%0d exp=0", ok_drop); end
        main_cs = 0;
        tick();
        checks++; if (main_ok !== 1'b0) begin failures++; $display("FAIL held_ok_clear got=%b exp=0", main_ok); end
        main_dout = 8'hA7; main_cs = 1; lm = 0; pulses = 0;
        for (int i = 1; i <= 8 && lm == 0; i++) begin
            tick();
            if (ram_we) pulses++;
            if (main_ok) lm = i;
        end
        checks++; if (lm !== 3) begin failures++; $display("FAIL regrant_lat got=%0d exp=3", lm); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL regrant_pulses got=%0d exp=1", pulses); end
        checks++; if (mem[10'h050] !== 8'hA7) begin failures++; $display("FAIL regrant_mem got=%h exp=a7", mem[10'h050]); end
        main_cs = 0; main_wrn = 1;
        tick();
    endtask

    task automatic test_async_reset();
        mem[10'h077] = 8'h33;
        main_wrn = 0; main_addr = 10'h077; main_dout = 8'hEE; main_cs = 1;
        tick();
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL areset_pre_we got=%b exp=1", ram_we); end
        checks++; if (ram_addr !== 10'h077) begin failures++; $display("FAIL areset_pre_addr got=%h exp=077", ram_addr); end
        #2 rst = 1;
        #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL areset_we got=%b exp=0", ram_we); end
        checks++;
        if ({main_din, sub_din, main_ok, sub_ok, ram_addr, ram_data, sub_busy} !== '0) begin
            failures++;
            $display("FAIL areset_outputs got=%h/%h/%b/%b/%h/%h/%b exp=all0",
                     main_din, sub_din, main_ok, sub_ok, ram_addr, ram_data, sub_busy);
        end
        main_cs = 0; main_wrn = 1;
        tick();
        checks++; if (mem[10'h077] !== 8'h33) begin failures++; $display("FAIL areset_no_write got=%h exp=33", mem[10'h077]); end
        rst = 0;
        run_tie(10'h016, 10'h017, 8'h77, 8'h88, 3, 6, "tie_post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_main_read();
        test_sub_write();
        test_tie();
        test_halt();
        test_held_cs();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
